// File: rtl/tconv_layer_batch_sequencer.sv
// Layer/batch sequencer ahead of the transpose-conv tile scheduler: load -> kick -> run per batch.
// Latency 1 cycle per handshake step; waits on load_ack/sched_done, abort returns to IDLE next cycle.
module tconv_layer_batch_sequencer #(
  parameter int L0_BATCHES = 8,
  parameter int L1_BATCHES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] cfg_first_layer,
  input  logic [1:0] cfg_last_layer,
  output logic       load_req,
  output logic [1:0] load_layer_id,
  output logic [2:0] load_batch_id,
  input  logic       load_ack,
  output logic       sched_start,
  output logic [1:0] sched_layer_id,
  output logic [2:0] sched_batch_id,
  input  logic       sched_done,
  output logic       busy,
  output logic       layer_done,
  output logic       all_done,
  output logic       cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_KICK, S_RUN} state_t;

  state_t     r_state;
  logic [1:0] r_layer;
  logic [1:0] r_last;
  logic [2:0] r_batch;
  logic [1:0] r_sched_layer;
  logic [2:0] r_sched_batch;
  logic       r_load_req;
  logic       r_sched_start;
  logic       r_busy;
  logic       r_layer_done;
  logic       r_all_done;
  logic       r_cfg_err;

  logic       w_cfg_bad;
  logic [2:0] w_last_batch;
  logic       w_batch_end;
  logic       w_layer_end;

  assign w_cfg_bad    = (cfg_first_layer > cfg_last_layer) || (cfg_last_layer > 2'd1);
  assign w_last_batch = (r_layer == 2'd0) ? 3'(L0_BATCHES - 1) : 3'(L1_BATCHES - 1);
  assign w_batch_end  = (r_batch == w_last_batch);
  assign w_layer_end  = (r_layer == r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_layer       <= 2'd0;
      r_last        <= 2'd0;
      r_batch       <= 3'd0;
      r_sched_layer <= 2'd0;
      r_sched_batch <= 3'd0;
      r_load_req    <= 1'b0;
      r_sched_start <= 1'b0;
      r_busy        <= 1'b0;
      r_layer_done  <= 1'b0;
      r_all_done    <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      // Pulse outputs default low; each state raises them for exactly one cycle.
      r_sched_start <= 1'b0;
      r_layer_done  <= 1'b0;
      r_all_done    <= 1'b0;
      r_cfg_err     <= 1'b0;
      if (abort) begin
        r_state    <= S_IDLE;
        r_load_req <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (w_cfg_bad) begin
                r_cfg_err <= 1'b1;
              end else begin
                r_last     <= cfg_last_layer;
                r_layer    <= cfg_first_layer;
                r_batch    <= 3'd0;
                r_load_req <= 1'b1;
                r_busy     <= 1'b1;
                r_state    <= S_LOAD;
              end
            end
          end
          S_LOAD: begin
            if (load_ack) begin
              r_load_req    <= 1'b0;
              r_sched_start <= 1'b1;
              r_sched_layer <= r_layer;
              r_sched_batch <= r_batch;
              r_state       <= S_KICK;
            end
          end
          S_KICK: r_state <= S_RUN;
          S_RUN: begin
            if (sched_done) begin
              if (!w_batch_end) begin
                r_batch    <= r_batch + 3'd1;
                r_load_req <= 1'b1;
                r_state    <= S_LOAD;
              end else if (!w_layer_end) begin
                r_layer      <= r_layer + 2'd1;
                r_batch      <= 3'd0;
                r_layer_done <= 1'b1;
                r_load_req   <= 1'b1;
                r_state      <= S_LOAD;
              end else begin
                r_layer_done <= 1'b1;
                r_all_done   <= 1'b1;
                r_busy       <= 1'b0;
                r_state      <= S_IDLE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign load_req       = r_load_req;
  assign load_layer_id  = r_layer;
  assign load_batch_id  = r_batch;
  assign sched_start    = r_sched_start;
  assign sched_layer_id = r_sched_layer;
  assign sched_batch_id = r_sched_batch;
  assign busy           = r_busy;
  assign layer_done     = r_layer_done;
  assign all_done       = r_all_done;
  assign cfg_err        = r_cfg_err;

endmodule

// File: tb/tb_tconv_layer_batch_sequencer.sv
// Directed bench for tconv_layer_batch_sequencer: full runs, config rejects, abort, strays, reset.
module tb_tconv_layer_batch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] cfg_first_layer = 2'd0;
  logic [1:0] cfg_last_layer = 2'd0;
  logic       load_req;
  logic [1:0] load_layer_id;
  logic [2:0] load_batch_id;
  logic       load_ack = 1'b0;
  logic       sched_start;
  logic [1:0] sched_layer_id;
  logic [2:0] sched_batch_id;
  logic       sched_done = 1'b0;
  logic       busy;
  logic       layer_done;
  logic       all_done;
  logic       cfg_err;

  int total = 0;
  int bad = 0;
  int n_kick = 0;
  int n_layer_done = 0;
  int n_all_done = 0;

  always #5 clk = ~clk;

  tconv_layer_batch_sequencer #(.L0_BATCHES(8), .L1_BATCHES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_first_layer(cfg_first_layer), .cfg_last_layer(cfg_last_layer),
    .load_req(load_req), .load_layer_id(load_layer_id), .load_batch_id(load_batch_id),
    .load_ack(load_ack), .sched_start(sched_start), .sched_layer_id(sched_layer_id),
    .sched_batch_id(sched_batch_id), .sched_done(sched_done), .busy(busy),
    .layer_done(layer_done), .all_done(all_done), .cfg_err(cfg_err)
  );

  always @(negedge clk) begin
    if (sched_start) n_kick++;
    if (layer_done) n_layer_done++;
    if (all_done) n_all_done++;
  end

  task automatic do_start(input logic [1:0] f, input logic [1:0] l);
    @(negedge clk);
    cfg_first_layer = f;
    cfg_last_layer = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One batch: wait for load_req, ack it, check the kick, then return sched_done 20 cycles after start.
  task automatic do_batch(input logic [1:0] l, input logic [2:0] b, input bit abort_at_done);
    int waited = 0;
    while (!load_req && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (!load_req) begin bad++; $display("FAIL load_req_timeout (%0d,%0d): got=0 exp=1", l, b); end
    total++;
    if (load_layer_id !== l || load_batch_id !== b) begin
      bad++; $display("FAIL load_ids: got=(%0d,%0d) exp=(%0d,%0d)", load_layer_id, load_batch_id, l, b);
    end
    load_ack = 1'b1;
    @(negedge clk);
    load_ack = 1'b0;
    total++;
    if (sched_start !== 1'b1 || load_req !== 1'b0) begin
      bad++; $display("FAIL kick (%0d,%0d): sched_start=%b load_req=%b exp 1,0", l, b, sched_start, load_req);
    end
    total++;
    if (sched_layer_id !== l || sched_batch_id !== b) begin
      bad++; $display("FAIL sched_ids: got=(%0d,%0d) exp=(%0d,%0d)", sched_layer_id, sched_batch_id, l, b);
    end
    repeat (19) @(negedge clk);
    total++;
    if (sched_layer_id !== l || sched_batch_id !== b || sched_start !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL run_stable (%0d,%0d): ids=(%0d,%0d) start=%b busy=%b", l, b,
                      sched_layer_id, sched_batch_id, sched_start, busy);
    end
    sched_done = 1'b1;
    abort = abort_at_done;
    @(negedge clk);
    sched_done = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({load_req, sched_start, busy, layer_done, all_done, cfg_err} !== 6'b0 ||
        load_layer_id !== 2'd0 || load_batch_id !== 3'd0 || sched_layer_id !== 2'd0 || sched_batch_id !== 3'd0) begin
      bad++; $display("FAIL reset_outputs: req=%b kick=%b busy=%b ids=%0d/%0d/%0d/%0d exp all 0",
                      load_req, sched_start, busy, load_layer_id, load_batch_id, sched_layer_id, sched_batch_id);
    end
  endtask

  task automatic test_single_layer();
    int k0 = n_kick, ld0 = n_layer_done, ad0 = n_all_done;
    do_start(2'd0, 2'd0);
    total++;
    if (load_req !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL start_latency: req=%b busy=%b exp 1,1", load_req, busy); end
    for (int b = 0; b < 8; b++) do_batch(2'd0, 3'(b), 1'b0);
    total++;
    if (layer_done !== 1'b1 || all_done !== 1'b1 || busy !== 1'b0 || load_req !== 1'b0) begin
      bad++; $display("FAIL t1_done: ld=%b ad=%b busy=%b req=%b exp 1,1,0,0", layer_done, all_done, busy, load_req);
    end
    @(negedge clk);
    total++;
    if (n_kick - k0 != 8 || n_layer_done - ld0 != 1 || n_all_done - ad0 != 1) begin
      bad++; $display("FAIL t1_counts: kicks=%0d ld=%0d ad=%0d exp 8,1,1", n_kick - k0, n_layer_done - ld0, n_all_done - ad0);
    end
  endtask

  task automatic test_two_layers();
    int k0 = n_kick, ld0 = n_layer_done, ad0 = n_all_done;
    do_start(2'd0, 2'd1);
    for (int b = 0; b < 8; b++) do_batch(2'd0, 3'(b), 1'b0);
    total++;
    if (layer_done !== 1'b1 || all_done !== 1'b0 || load_req !== 1'b1) begin
      bad++; $display("FAIL t2_layer_adv: ld=%b ad=%b req=%b exp 1,0,1", layer_done, all_done, load_req);
    end
    for (int b = 0; b < 4; b++) do_batch(2'd1, 3'(b), 1'b0);
    total++;
    if (layer_done !== 1'b1 || all_done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL t2_done: ld=%b ad=%b busy=%b exp 1,1,0", layer_done, all_done, busy);
    end
    @(negedge clk);
    total++;
    if (n_kick - k0 != 12 || n_layer_done - ld0 != 2 || n_all_done - ad0 != 1) begin
      bad++; $display("FAIL t2_counts: kicks=%0d ld=%0d ad=%0d exp 12,2,1", n_kick - k0, n_layer_done - ld0, n_all_done - ad0);
    end
  endtask

  task automatic test_cfg_reject();
    logic [1:0] bad_first [3] = '{2'd1, 2'd0, 2'd2};
    logic [1:0] bad_last  [3] = '{2'd0, 2'd2, 2'd3};
    for (int i = 0; i < 3; i++) begin
      do_start(bad_first[i], bad_last[i]);
      total++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || load_req !== 1'b0) begin
        bad++; $display("FAIL cfg_reject %0d: err=%b busy=%b req=%b exp 1,0,0", i, cfg_err, busy, load_req);
      end
    end
    @(negedge clk);
    total++;
    if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_pulse: got=%b exp=0", cfg_err); end
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || load_req !== 1'b0) begin
      bad++; $display("FAIL abort_vs_start: busy=%b req=%b exp 0,0", busy, load_req);
    end
  endtask

  task automatic test_abort();
    int ld0;
    do_start(2'd0, 2'd0);
    for (int b = 0; b < 3; b++) do_batch(2'd0, 3'(b), 1'b0);
    ld0 = n_layer_done;
    do_batch(2'd0, 3'd3, 1'b1);
    total++;
    if (busy !== 1'b0 || load_req !== 1'b0 || sched_start !== 1'b0 || layer_done !== 1'b0 || all_done !== 1'b0) begin
      bad++; $display("FAIL abort_run: busy=%b req=%b kick=%b ld=%b ad=%b exp all 0",
                      busy, load_req, sched_start, layer_done, all_done);
    end
    repeat (5) @(negedge clk);
    total++;
    if (n_layer_done != ld0 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_idle: extra_ld=%0d busy=%b exp 0,0", n_layer_done - ld0, busy);
    end
    do_start(2'd1, 2'd1);
    for (int b = 0; b < 4; b++) do_batch(2'd1, 3'(b), 1'b0);
    total++;
    if (all_done !== 1'b1) begin bad++; $display("FAIL restart_done: all_done=%b exp=1", all_done); end
  endtask

  task automatic test_strays();
    do_start(2'd0, 2'd0);
    sched_done = 1'b1;
    @(negedge clk);
    sched_done = 1'b0;
    total++;
    if (load_req !== 1'b1 || sched_start !== 1'b0 || load_layer_id !== 2'd0 || load_batch_id !== 3'd0) begin
      bad++; $display("FAIL stray_done_in_load: req=%b kick=%b ids=(%0d,%0d) exp 1,0,(0,0)",
                      load_req, sched_start, load_layer_id, load_batch_id);
    end
    load_ack = 1'b1;
    @(negedge clk);
    load_ack = 1'b0;
    repeat (3) @(negedge clk);
    load_ack = 1'b1;
    start = 1'b1;
    cfg_first_layer = 2'd1;
    cfg_last_layer = 2'd1;
    @(negedge clk);
    load_ack = 1'b0;
    start = 1'b0;
    total++;
    if (load_req !== 1'b0 || sched_start !== 1'b0 || busy !== 1'b1 ||
        sched_layer_id !== 2'd0 || sched_batch_id !== 3'd0 || load_batch_id !== 3'd0) begin
      bad++; $display("FAIL stray_in_run: req=%b kick=%b busy=%b sched=(%0d,%0d) lb=%0d exp 0,0,1,(0,0),0",
                      load_req, sched_start, busy, sched_layer_id, sched_batch_id, load_batch_id);
    end
    sched_done = 1'b1;
    @(negedge clk);
    sched_done = 1'b0;
    total++;
    if (load_req !== 1'b1 || load_layer_id !== 2'd0 || load_batch_id !== 3'd1) begin
      bad++; $display("FAIL after_strays: req=%b ids=(%0d,%0d) exp 1,(0,1)", load_req, load_layer_id, load_batch_id);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || load_req !== 1'b0) begin bad++; $display("FAIL abort_load: busy=%b req=%b exp 0,0", busy, load_req); end
  endtask

  task automatic test_reset_mid_run();
    do_start(2'd0, 2'd1);
    for (int b = 0; b < 8; b++) do_batch(2'd0, 3'(b), 1'b0);
    for (int b = 0; b < 2; b++) do_batch(2'd1, 3'(b), 1'b0);
    load_ack = 1'b1;
    @(negedge clk);
    load_ack = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (sched_layer_id !== 2'd1 || sched_batch_id !== 3'd2 || busy !== 1'b1) begin
      bad++; $display("FAIL pre_reset_run: sched=(%0d,%0d) busy=%b exp (1,2),1", sched_layer_id, sched_batch_id, busy);
    end
    rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_start(2'd0, 2'd0);
    total++;
    if (load_req !== 1'b1 || load_layer_id !== 2'd0 || load_batch_id !== 3'd0) begin
      bad++; $display("FAIL restart_after_reset: req=%b ids=(%0d,%0d) exp 1,(0,0)", load_req, load_layer_id, load_batch_id);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_single_layer();
    test_two_layers();
    test_cfg_reject();
    test_abort();
    test_strays();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
